uart_tx_bridge: RTL and testbench

Serializing transmitter for the CPU's 9-bit parallel UART output port `uart_out` (`[8]` = write strobe, `[7:0]` = byte). It sits between the `RV32IM` core and the board/testbench serial pin. Bytes written by the core are buffered in a small FIFO and shifted out as 8N1 frames, LSB first, at a fixed clocks-per-bit rate. It is the line-side end of the interface on which the core is the writer.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_bridge.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_bridge.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit bridge.
package uart_pkg;

   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_PARITY,
      UART_STOP
   } uart_state_t;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STB_BIT   = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with combinational head; a push while full is accepted only if a pop lands on the same edge.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [UART_DATA_BITS-1:0] wdata,
   output logic [UART_DATA_BITS-1:0] rdata,
   output logic [AW:0]               count,
   output logic                      full,
   output logic                      empty
);

   logic [UART_DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]             wr_ptr;
   logic [AW-1:0]             rd_ptr;
   logic                      push_ok;
   logic                      pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_bridge.sv
// Serializes bytes strobed by the core into 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
//
// state       | meaning
// UART_IDLE   | line high, waiting for a queued byte
// UART_START  | start bit (low)
// UART_DATA   | eight data bits, LSB first
// UART_PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// UART_STOP   | stop bit (high); chains straight into START if more bytes are queued
module uart_tx_bridge
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [UART_STB_BIT:0] uart_in,
   output logic                  txd,
   output logic                  busy,
   output logic                  fifo_full,
   output logic                  overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_state_t               state, state_next;
   logic [BW-1:0]             baud, baud_next;
   logic [2:0]                bit_idx, bit_next;
   logic [UART_DATA_BITS-1:0] shift, shift_next;
   logic                      txd_next;
   logic                      pop;
   logic                      strobe;
   logic                      tc;
   logic [UART_DATA_BITS-1:0] fifo_rdata;
   logic [CW-1:0]             fifo_count;
   logic                      fifo_empty;

   assign strobe = uart_in[UART_STB_BIT];
   assign tc     = (baud == '0);
   assign busy   = (state != UART_IDLE) || (fifo_count != '0);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (strobe),
      .pop     (pop),
      .wdata   (uart_in[UART_DATA_BITS-1:0]),
      .rdata   (fifo_rdata),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef UART_TX_PARITY_EN
   logic par_q;

   // Parity is latched at pop time because the shifter consumes the byte.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         par_q <= 1'b0;
      end else if (pop) begin
         par_q <= ^fifo_rdata;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (strobe && fifo_full && !pop) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= UART_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         txd     <= 1'b1;
      end else begin
         state   <= state_next;
         baud    <= baud_next;
         bit_idx <= bit_next;
         shift   <= shift_next;
         txd     <= txd_next;
      end
   end

   always_comb begin
      state_next = state;
      baud_next  = baud - 1'b1;
      bit_next   = bit_idx;
      shift_next = shift;
      txd_next   = txd;
      pop        = 1'b0;
      case (state)
         UART_IDLE: begin
            baud_next = '0;
            txd_next  = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_rdata;
               state_next = UART_START;
               baud_next  = BAUD_LOAD;
               txd_next   = 1'b0;
            end
         end
         UART_START: begin
            txd_next = 1'b0;
            if (tc) begin
               state_next = UART_DATA;
               baud_next  = BAUD_LOAD;
               bit_next   = '0;
               txd_next   = shift[0];
            end
         end
         UART_DATA: begin
            txd_next = shift[0];
            if (tc) begin
               baud_next = BAUD_LOAD;
               if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_next = UART_PARITY;
                  txd_next   = par_q;
`else
                  state_next = UART_STOP;
                  txd_next   = 1'b1;
`endif
               end else begin
                  bit_next   = bit_idx + 1'b1;
                  shift_next = shift >> 1;
                  txd_next   = shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         UART_PARITY: begin
            txd_next = par_q;
            if (tc) begin
               state_next = UART_STOP;
               baud_next  = BAUD_LOAD;
               txd_next   = 1'b1;
            end
         end
`endif
         UART_STOP: begin
            txd_next = 1'b1;
            if (tc) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_rdata;
                  state_next = UART_START;
                  baud_next  = BAUD_LOAD;
                  txd_next   = 1'b0;
               end else begin
                  state_next = UART_IDLE;
                  baud_next  = '0;
               end
            end
         end
         default: begin
            state_next = UART_IDLE;
            baud_next  = '0;
            txd_next   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Directed bench for uart_tx_bridge: logs txd/busy every cycle and checks frame windows against hand-built bit patterns.
module tb_uart_tx_bridge;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;
   localparam int LOG   = 8192;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [8:0] uart_in = '0;
   logic       txd;
   logic       busy;
   logic       fifo_full;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;
   int ncyc     = 0;
   logic txd_log  [LOG];
   logic busy_log [LOG];

   uart_tx_bridge #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .uart_in   (uart_in),
      .txd       (txd),
      .busy      (busy),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (ncyc < LOG) begin
         txd_log[ncyc]  = txd;
         busy_log[ncyc] = busy;
      end
      ncyc = ncyc + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      uart_in = {1'b1, b};
      tick();
      uart_in = '0;
   endtask

   // Compares one frame window of the log; busy must be high for its whole length.
   task automatic check_frame(input string tag, input int start, input logic [7:0] b);
      logic [63:0] obs, exp, bobs, bexp;
      int pos;
      obs = '0; exp = '0; bobs = '0; bexp = '0;
      for (int i = 0; i < FRAME; i++) begin
         pos = i / CPB;
         if (pos == 0)                 exp[i] = 1'b0;
         else if (pos <= 8)            exp[i] = b[pos-1];
         else if (NBITS == 11 && pos == 9) exp[i] = ^b;
         else                          exp[i] = 1'b1;
         obs[i]  = txd_log[start+i];
         bobs[i] = busy_log[start+i];
         bexp[i] = 1'b1;
      end
      check_eq({tag, "_txd"}, obs, exp);
      check_eq({tag, "_busy"}, bobs, bexp);
   endtask

   task automatic check_idle(input string tag, input int start, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (txd_log[start+i] !== 1'b1 || busy_log[start+i] !== 1'b0) bad++;
      end
      check_eq(tag, 64'(bad), 64'd0);
   endtask

   initial begin
      int s;

      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      check_eq("rst_txd", 64'(txd), 64'd1);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_full", 64'(fifo_full), 64'd0);
      check_eq("rst_ovf", 64'(overflow), 64'd0);

      // single byte
      wr_byte(8'h41);
      s = ncyc;
      check_eq("t1_busy_after_write", 64'(busy), 64'd1);
      check_eq("t1_txd_still_high", 64'(txd), 64'd1);
      tick();
      check_eq("t1_latency", 64'(txd), 64'd0);
      repeat (FRAME + 8) tick();
      check_frame("t1_frame", s + 1, 8'h41);
      check_idle("t1_after", s + 1 + FRAME, 6);

      // back-to-back
      uart_in = {1'b1, 8'h55};
      tick();
      s = ncyc;
      uart_in = {1'b1, 8'hAA};
      tick();
      uart_in = '0;
      repeat (2 * FRAME + 8) tick();
      check_frame("t2_f0", s + 1, 8'h55);
      check_frame("t2_f1", s + 1 + FRAME, 8'hAA);
      check_idle("t2_after", s + 1 + 2 * FRAME, 6);

      // overflow
      for (int i = 0; i < 10; i++) begin
         uart_in = {1'b1, 8'(i)};
         tick();
         if (i == 0) s = ncyc;
         if (i == 8) begin
            check_eq("t3_full_at9", 64'(fifo_full), 64'd1);
            check_eq("t3_ovf_at9", 64'(overflow), 64'd0);
         end
      end
      uart_in = '0;
      check_eq("t3_full", 64'(fifo_full), 64'd1);
      check_eq("t3_ovf", 64'(overflow), 64'd1);
      repeat (9 * FRAME + 50) tick();
      for (int k = 0; k < 9; k++) begin
         check_frame($sformatf("t3_f%0d", k), s + 1 + k * FRAME, 8'(k));
      end
      check_idle("t3_no_tenth", s + 1 + 9 * FRAME, 45);
      check_eq("t3_ovf_sticky", 64'(overflow), 64'd1);
      check_eq("t3_full_clear", 64'(fifo_full), 64'd0);

      // reset mid-frame with three bytes queued
      wr_byte(8'h11);
      wr_byte(8'h22);
      wr_byte(8'h33);
      wr_byte(8'h44);
      repeat (10) tick();
      check_eq("t4_busy_pre", 64'(busy), 64'd1);
      reset_n = 1'b0;
      tick();
      check_eq("t4_txd", 64'(txd), 64'd1);
      check_eq("t4_busy", 64'(busy), 64'd0);
      check_eq("t4_full", 64'(fifo_full), 64'd0);
      check_eq("t4_ovf", 64'(overflow), 64'd0);
      reset_n = 1'b1;
      s = ncyc;
      repeat (100) tick();
      check_idle("t4_no_frames", s, 98);

`ifdef UART_TX_PARITY_EN
      wr_byte(8'h07);
      s = ncyc;
      repeat (FRAME + 8) tick();
      check_frame("t5_p07", s + 1, 8'h07);
      check_eq("t5_p07_bit", 64'(txd_log[s + 1 + 9 * CPB]), 64'd1);
      check_idle("t5_p07_len", s + 1 + FRAME, 6);
      wr_byte(8'h03);
      s = ncyc;
      repeat (FRAME + 8) tick();
      check_frame("t5_p03", s + 1, 8'h03);
      check_eq("t5_p03_bit", 64'(txd_log[s + 1 + 9 * CPB]), 64'd0);
`endif

      // strobe low, data toggling
      s = ncyc;
      for (int i = 0; i < 100; i++) begin
         uart_in = {1'b0, 8'(i * 37 + 5)};
         tick();
      end
      uart_in = '0;
      repeat (4) tick();
      check_idle("t6_no_strobe", s, 102);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
